// File: rtl/ltl_nfa_engine_pkg.sv
// Shared types for the programmable LTL NFA engine: configuration kinds,
// STE start types and the configuration payload width helper.
package ltl_nfa_pkg;

  // Kind of table addressed by a configuration write
  typedef enum logic [1:0] {
    CFG_INTV = 2'd0,
    CFG_ADJ  = 2'd1,
    CFG_ATTR = 2'd2
  } cfg_kind_e;

  // How an STE may become enabled without an incoming edge
  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_SOD  = 2'd1,
    ST_ALL  = 2'd2
  } start_type_e;

  // Configuration payload must carry an interval {valid,hi,lo}, an adjacency
  // row, or the 3-bit attribute word, whichever is widest.
  function automatic int cfg_width(input int sym_w, input int n_states);
    int w;
    w = 2 * sym_w + 1;
    if (n_states > w) begin
      w = n_states;
    end else begin
      w = w;
    end
    if (w < 3) begin
      w = 3;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/ltl_nfa_engine_evt_fifo.sv
// Report-event FIFO. A push into a full FIFO is still accepted when the head
// is popped in the same cycle; otherwise it is dropped and drop_o pulses.
module ltl_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         drop_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  logic full_s;
  logic pop_s;
  logic accept_s;

  assign full_s   = (cnt_q == CW'(DEPTH));
  assign valid_o  = (cnt_q != '0);
  assign data_o   = mem_q[rd_q];
  assign pop_s    = valid_o & ready_i;
  assign accept_s = push_i & (~full_s | pop_s);
  assign drop_o   = push_i & full_s & ~pop_s;

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (accept_s) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_s) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({accept_s, pop_s})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ltl_nfa_engine.sv
// Runtime-programmable NFA engine: N_STATES STEs with interval symbol
// classes, programmable edges, sticky reporting and a timestamped event FIFO.
module ltl_nfa_engine
  import ltl_nfa_pkg::*;
#(
  parameter int N_STATES   = 9,
  parameter int SYM_W      = 8,
  parameter int N_INTV     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_W       = 16,
  localparam int ST_W      = (N_STATES > 1) ? $clog2(N_STATES) : 1,
  localparam int IDX_W     = (N_INTV > 1) ? $clog2(N_INTV) : 1,
  localparam int CFG_W     = cfg_width(SYM_W, N_STATES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [SYM_W-1:0]    symbols,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_kind,
  input  logic [ST_W-1:0]     cfg_state,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [CFG_W-1:0]    cfg_data,
  input  logic                clear_sticky,
  output logic [N_STATES-1:0] active_state,
  output logic [N_STATES-1:0] report,
  output logic [N_STATES-1:0] report_sticky,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [N_STATES-1:0] evt_report,
  output logic [TS_W-1:0]     evt_time,
  output logic                evt_overflow
);

  typedef struct packed {
    logic             valid;
    logic [SYM_W-1:0] hi;
    logic [SYM_W-1:0] lo;
  } intv_t;

  // Configuration tables
  intv_t               intv_q  [N_STATES][N_INTV];
  logic [N_STATES-1:0] adj_q   [N_STATES];
  logic [1:0]          stype_q [N_STATES];
  logic [N_STATES-1:0] rmask_q;

  // Run-time state
  logic [N_STATES-1:0] active_q;
  logic                sod_q;
  logic [TS_W-1:0]     ts_q;
  logic [N_STATES-1:0] sticky_q;
  logic [N_STATES-1:0] sticky_d;
  logic                ovf_q;
  logic                ovf_d;

  logic                cfg_en_s;
  logic [N_STATES-1:0] match_s;
  logic [N_STATES-1:0] enable_s;
  logic [N_STATES-1:0] next_active_s;
  logic [N_STATES-1:0] next_report_s;
  logic                push_s;
  logic                drop_s;
  logic [TS_W+N_STATES-1:0] head_s;
  logic                unused_cfg_s;

  // Configuration is frozen while symbols are flowing
  assign cfg_en_s     = cfg_we & ~run;
  assign unused_cfg_s = ^cfg_data;

  // Configuration table writes, decoded by kind, STE and interval index
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_STATES; i++) begin
        adj_q[i]   <= '0;
        stype_q[i] <= 2'd0;
        for (int k = 0; k < N_INTV; k++) begin
          intv_q[i][k] <= '0;
        end
      end
      rmask_q <= '0;
    end else if (cfg_en_s) begin
      for (int i = 0; i < N_STATES; i++) begin
        if (cfg_state == ST_W'(i)) begin
          case (cfg_kind)
            CFG_INTV: begin
              for (int k = 0; k < N_INTV; k++) begin
                if (cfg_idx == IDX_W'(k)) begin
                  intv_q[i][k].valid <= cfg_data[2*SYM_W];
                  intv_q[i][k].hi    <= cfg_data[2*SYM_W-1:SYM_W];
                  intv_q[i][k].lo    <= cfg_data[SYM_W-1:0];
                end
              end
            end
            CFG_ADJ:  adj_q[i] <= cfg_data[N_STATES-1:0];
            CFG_ATTR: begin
              stype_q[i] <= cfg_data[1:0];
              rmask_q[i] <= cfg_data[2];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Per-STE symbol match and enable; start type 3 behaves as ST_NONE
  for (genvar g = 0; g < N_STATES; g++) begin : g_ste
    logic [N_INTV-1:0] hit_s;
    for (genvar k = 0; k < N_INTV; k++) begin : g_intv
      assign hit_s[k] = intv_q[g][k].valid
                      & (symbols >= intv_q[g][k].lo)
                      & (symbols <= intv_q[g][k].hi);
    end
    assign match_s[g]  = |hit_s;
    assign enable_s[g] = (stype_q[g] == ST_ALL)
                       | ((stype_q[g] == ST_SOD) & sod_q)
                       | (|(adj_q[g] & active_q));
  end

  assign next_active_s = enable_s & match_s;
  assign next_report_s = next_active_s & rmask_q;
  assign push_s        = run & (|next_report_s);

  // Sticky status next-state: a same-cycle set beats clear_sticky
  always_comb begin
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    if (clear_sticky) begin
      sticky_d = '0;
      ovf_d    = 1'b0;
    end else begin
      sticky_d = sticky_q;
      ovf_d    = ovf_q;
    end
    if (run) begin
      sticky_d = sticky_d | next_report_s;
    end else begin
      sticky_d = sticky_d;
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
  end

  // STE activity, start-of-data flag, symbol timestamp and sticky status
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= '0;
      sod_q    <= 1'b1;
      ts_q     <= '0;
      sticky_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (run) begin
        active_q <= next_active_s;
        sod_q    <= 1'b0;
        ts_q     <= ts_q + TS_W'(1);
      end
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  // Events carry the index of the symbol that produced them
  ltl_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (TS_W + N_STATES)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .data_i  ({ts_q, next_report_s}),
    .ready_i (evt_ready),
    .valid_o (evt_valid),
    .data_o  (head_s),
    .drop_o  (drop_s)
  );

  assign evt_time      = head_s[TS_W+N_STATES-1:N_STATES];
  assign evt_report    = head_s[N_STATES-1:0];
  assign active_state  = active_q;
  assign report        = active_q & rmask_q;
  assign report_sticky = sticky_q;
  assign evt_overflow  = ovf_q;

endmodule

// File: tb/tb_ltl_nfa_engine.sv
// Directed, table-driven bench for ltl_nfa_engine (4 STEs, 4-deep FIFO).
module tb_ltl_nfa_engine;

  localparam int NS = 4;
  localparam int SW = 8;
  localparam int NI = 4;
  localparam int FD = 4;
  localparam int TW = 16;
  localparam int CW = 17;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [SW-1:0] symbols;
  logic          cfg_we;
  logic [1:0]    cfg_kind;
  logic [1:0]    cfg_state;
  logic [1:0]    cfg_idx;
  logic [CW-1:0] cfg_data;
  logic          clear_sticky;
  logic [NS-1:0] active_state;
  logic [NS-1:0] report;
  logic [NS-1:0] report_sticky;
  logic          evt_valid;
  logic          evt_ready;
  logic [NS-1:0] evt_report;
  logic [TW-1:0] evt_time;
  logic          evt_overflow;

  ltl_nfa_engine #(
    .N_STATES(NS), .SYM_W(SW), .N_INTV(NI), .FIFO_DEPTH(FD), .TS_W(TW)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .symbols(symbols),
    .cfg_we(cfg_we), .cfg_kind(cfg_kind), .cfg_state(cfg_state),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data), .clear_sticky(clear_sticky),
    .active_state(active_state), .report(report), .report_sticky(report_sticky),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_report(evt_report),
    .evt_time(evt_time), .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        run;
    logic [7:0]  sym;
    logic        rdy;
    logic        clr;
    logic [3:0]  act;
    logic [3:0]  rep;
    logic        vld;
    logic [15:0] tm;
    logic [3:0]  erep;
    logic [3:0]  stk;
    logic        ovf;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] iv(input logic v, input logic [7:0] hi, input logic [7:0] lo);
    return {v, hi, lo};
  endfunction

  task automatic add(input logic r, input logic [7:0] s, input logic rdy, input logic clr,
                     input logic [3:0] act, input logic [3:0] rep, input logic vld,
                     input logic [15:0] tm, input logic [3:0] erep, input logic [3:0] stk,
                     input logic ovf);
    vq.push_back('{r, s, rdy, clr, act, rep, vld, tm, erep, stk, ovf});
  endtask

  task automatic run_table(input string tag);
    foreach (vq[n]) begin
      run          = vq[n].run;
      symbols      = vq[n].sym;
      evt_ready    = vq[n].rdy;
      clear_sticky = vq[n].clr;
      @(posedge clk); #1;
      check($sformatf("%s[%0d].active", tag, n), 32'(active_state), 32'(vq[n].act));
      check($sformatf("%s[%0d].report", tag, n), 32'(report), 32'(vq[n].rep));
      check($sformatf("%s[%0d].evt_valid", tag, n), 32'(evt_valid), 32'(vq[n].vld));
      check($sformatf("%s[%0d].sticky", tag, n), 32'(report_sticky), 32'(vq[n].stk));
      check($sformatf("%s[%0d].overflow", tag, n), 32'(evt_overflow), 32'(vq[n].ovf));
      if (vq[n].vld) begin
        check($sformatf("%s[%0d].evt_time", tag, n), 32'(evt_time), 32'(vq[n].tm));
        check($sformatf("%s[%0d].evt_report", tag, n), 32'(evt_report), 32'(vq[n].erep));
      end
    end
    vq.delete();
    run          = 1'b0;
    evt_ready    = 1'b0;
    clear_sticky = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] kind, input logic [1:0] st,
                           input logic [1:0] idx, input logic [CW-1:0] data);
    run       = 1'b0;
    cfg_we    = 1'b1;
    cfg_kind  = kind;
    cfg_state = st;
    cfg_idx   = idx;
    cfg_data  = data;
    @(posedge clk); #1;
    cfg_we    = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; run = 1'b0; cfg_we = 1'b0; evt_ready = 1'b0;
    clear_sticky = 1'b0; symbols = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    check({tag, ".rst_active"}, 32'(active_state), 32'd0);
    check({tag, ".rst_report"}, 32'(report), 32'd0);
    check({tag, ".rst_valid"}, 32'(evt_valid), 32'd0);
    check({tag, ".rst_sticky"}, 32'(report_sticky), 32'd0);
    check({tag, ".rst_overflow"}, 32'(evt_overflow), 32'd0);
  endtask

  // STE0: all-input on [32,47]; STE1: fed by STE0, matches anything; both report
  task automatic cfg_chain();
    cfg_write(2'd0, 2'd0, 2'd0, iv(1'b1, 8'd47, 8'd32));
    cfg_write(2'd2, 2'd0, 2'd0, 17'(3'b110));
    cfg_write(2'd1, 2'd1, 2'd0, 17'(4'b0001));
    cfg_write(2'd0, 2'd1, 2'd0, iv(1'b1, 8'd255, 8'd0));
    cfg_write(2'd2, 2'd1, 2'd0, 17'(3'b100));
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; symbols = '0; cfg_we = 1'b0; cfg_kind = '0;
    cfg_state = '0; cfg_idx = '0; cfg_data = '0; clear_sticky = 1'b0; evt_ready = 1'b0;

    // A: start-of-data STE fires only on the first symbol
    do_reset("A");
    cfg_write(2'd0, 2'd0, 2'd0, iv(1'b1, 8'd15, 8'd0));
    cfg_write(2'd2, 2'd0, 2'd0, 17'(3'b101));
    add(1, 8'd5, 0, 0, 4'h1, 4'h1, 1, 16'd0, 4'h1, 4'h1, 0);
    add(1, 8'd5, 0, 0, 4'h0, 4'h0, 1, 16'd0, 4'h1, 4'h1, 0);
    add(0, 8'd5, 1, 0, 4'h0, 4'h0, 0, 16'd0, 4'h0, 4'h1, 0);
    add(0, 8'd5, 1, 0, 4'h0, 4'h0, 0, 16'd0, 4'h0, 4'h1, 0);
    run_table("A");

    // B: edge from STE0 to STE1, three events timestamped 0,1,2
    do_reset("B");
    cfg_chain();
    add(1, 8'd40,  0, 0, 4'h1, 4'h1, 1, 16'd0, 4'h1, 4'h1, 0);
    add(1, 8'd200, 0, 0, 4'h2, 4'h2, 1, 16'd0, 4'h1, 4'h3, 0);
    add(1, 8'd40,  0, 0, 4'h1, 4'h1, 1, 16'd0, 4'h1, 4'h3, 0);
    add(0, 8'd40,  1, 0, 4'h1, 4'h1, 1, 16'd1, 4'h2, 4'h3, 0);
    add(0, 8'd40,  1, 0, 4'h1, 4'h1, 1, 16'd2, 4'h1, 4'h3, 0);
    add(0, 8'd40,  1, 0, 4'h1, 4'h1, 0, 16'd0, 4'h0, 4'h3, 0);
    run_table("B");

    // C: five idle cycles with toggling symbols hold everything
    do_reset("C");
    cfg_chain();
    add(1, 8'd40,  0, 0, 4'h1, 4'h1, 1, 16'd0, 4'h1, 4'h1, 0);
    add(0, 8'd200, 0, 0, 4'h1, 4'h1, 1, 16'd0, 4'h1, 4'h1, 0);
    add(0, 8'd40,  0, 0, 4'h1, 4'h1, 1, 16'd0, 4'h1, 4'h1, 0);
    add(0, 8'd0,   0, 0, 4'h1, 4'h1, 1, 16'd0, 4'h1, 4'h1, 0);
    add(0, 8'd255, 0, 0, 4'h1, 4'h1, 1, 16'd0, 4'h1, 4'h1, 0);
    add(0, 8'd200, 0, 0, 4'h1, 4'h1, 1, 16'd0, 4'h1, 4'h1, 0);
    add(1, 8'd200, 0, 0, 4'h2, 4'h2, 1, 16'd0, 4'h1, 4'h3, 0);
    add(0, 8'd0,   1, 0, 4'h2, 4'h2, 1, 16'd1, 4'h2, 4'h3, 0);
    add(0, 8'd0,   1, 0, 4'h2, 4'h2, 0, 16'd0, 4'h0, 4'h3, 0);
    run_table("C");

    // D: overflow, set-beats-clear, then push accepted at full with a pop
    do_reset("D");
    cfg_write(2'd0, 2'd0, 2'd2, iv(1'b1, 8'd255, 8'd0));
    cfg_write(2'd2, 2'd0, 2'd0, 17'(3'b110));
    for (int i = 0; i < 4; i++) begin
      add(1, 8'd7, 0, 0, 4'h1, 4'h1, 1, 16'd0, 4'h1, 4'h1, 0);
    end
    add(1, 8'd7, 0, 0, 4'h1, 4'h1, 1, 16'd0, 4'h1, 4'h1, 1);
    add(1, 8'd7, 0, 1, 4'h1, 4'h1, 1, 16'd0, 4'h1, 4'h1, 1);
    add(0, 8'd7, 0, 1, 4'h1, 4'h1, 1, 16'd0, 4'h1, 4'h0, 0);
    add(1, 8'd7, 1, 0, 4'h1, 4'h1, 1, 16'd1, 4'h1, 4'h1, 0);
    add(0, 8'd7, 1, 0, 4'h1, 4'h1, 1, 16'd2, 4'h1, 4'h1, 0);
    add(0, 8'd7, 1, 0, 4'h1, 4'h1, 1, 16'd3, 4'h1, 4'h1, 0);
    add(0, 8'd7, 1, 0, 4'h1, 4'h1, 1, 16'd6, 4'h1, 4'h1, 0);
    add(0, 8'd7, 1, 0, 4'h1, 4'h1, 0, 16'd0, 4'h0, 4'h1, 0);
    run_table("D");

    // E: configuration write during run is ignored, accepted when idle
    do_reset("E");
    cfg_write(2'd0, 2'd0, 2'd0, iv(1'b1, 8'd255, 8'd0));
    cfg_we = 1'b1; cfg_kind = 2'd2; cfg_state = 2'd0; cfg_idx = 2'd0;
    cfg_data = 17'(3'b110); run = 1'b1; symbols = 8'd9;
    @(posedge clk); #1;
    check("E.we_run_active", 32'(active_state), 32'd0);
    cfg_we = 1'b0;
    @(posedge clk); #1;
    check("E.ignored_active", 32'(active_state), 32'd0);
    check("E.ignored_valid", 32'(evt_valid), 32'd0);
    cfg_write(2'd2, 2'd0, 2'd0, 17'(3'b110));
    add(1, 8'd9, 0, 0, 4'h1, 4'h1, 1, 16'd2, 4'h1, 4'h1, 0);
    run_table("E");

    // F: reset mid-stream drops FIFO contents and clears configuration
    do_reset("F");
    cfg_write(2'd0, 2'd0, 2'd0, iv(1'b1, 8'd255, 8'd0));
    cfg_write(2'd2, 2'd0, 2'd0, 17'(3'b110));
    add(1, 8'd3, 0, 0, 4'h1, 4'h1, 1, 16'd0, 4'h1, 4'h1, 0);
    add(1, 8'd3, 0, 0, 4'h1, 4'h1, 1, 16'd0, 4'h1, 4'h1, 0);
    run_table("F1");
    do_reset("F");
    cfg_write(2'd2, 2'd0, 2'd0, 17'(3'b110));
    cfg_write(2'd0, 2'd1, 2'd0, iv(1'b1, 8'd255, 8'd0));
    cfg_write(2'd2, 2'd1, 2'd0, 17'(3'b101));
    cfg_write(2'd0, 2'd2, 2'd1, iv(1'b1, 8'd40, 8'd50));
    cfg_write(2'd2, 2'd2, 2'd0, 17'(3'b110));
    add(1, 8'd0,   0, 0, 4'h2, 4'h2, 1, 16'd0, 4'h2, 4'h2, 0);
    add(1, 8'd128, 0, 0, 4'h0, 4'h0, 1, 16'd0, 4'h2, 4'h2, 0);
    add(1, 8'd45,  0, 0, 4'h0, 4'h0, 1, 16'd0, 4'h2, 4'h2, 0);
    run_table("F2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
